// File: rtl/image_frame_packer.sv
// Drains four channel FIFOs as one set and streams a framed packet (header, seq, 8 payload bytes)
// through the UART byte handshake. Define FRAME_CHECKSUM_EN to append an XOR checksum byte.
module image_frame_packer #(
    parameter logic [7:0] FRAME_HDR = 8'hA5
) (
    input  logic        clk40M,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  empty,
    output logic [3:0]  rd,
    input  logic [63:0] fifoOut,
    output logic [7:0]  txData,
    output logic        txStart,
    input  logic        txDone,
    output logic        busy,
    output logic [15:0] frameCount
);

`ifdef FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, WAIT} state_t;

    state_t      state_reg;
    logic [63:0] payload_reg;
    logic [7:0]  seq_reg;
    logic [3:0]  idx_reg;
    logic [3:0]  rd_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_start_reg;
    logic        busy_reg;
    logic [15:0] frame_count_reg;

    logic [3:0]  idx_next;
    logic [3:0]  payload_idx;
    logic [7:0]  byte_next;
    logic [7:0]  payload_bytes [8];

    // Channel i occupies fifoOut[16*i +: 16], low byte first, so payload byte k is just slice k.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_payload_bytes
            assign payload_bytes[gi] = payload_reg[8*gi +: 8];
        end
    endgenerate

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum_chain [9];
    assign csum_chain[0] = seq_reg;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_csum
            assign csum_chain[gi+1] = csum_chain[gi] ^ payload_bytes[gi];
        end
    endgenerate
`endif

    assign idx_next    = idx_reg + 4'd1;
    assign payload_idx = idx_next - 4'd2;

    // Byte following the current one; the header is loaded directly on capture.
    always_comb begin
        byte_next = 8'h00;
        case (idx_next)
            4'd0:    byte_next = FRAME_HDR;
            4'd1:    byte_next = seq_reg;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                     byte_next = payload_bytes[payload_idx[2:0]];
`ifdef FRAME_CHECKSUM_EN
            4'd10:   byte_next = csum_chain[8];
`endif
            default: byte_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            payload_reg     <= 64'h0;
            seq_reg         <= 8'h00;
            idx_reg         <= 4'd0;
            rd_reg          <= 4'h0;
            tx_data_reg     <= 8'h00;
            tx_start_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            frame_count_reg <= 16'h0000;
        end else begin
            rd_reg       <= 4'h0;
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable && (empty == 4'h0)) begin
                        state_reg <= READ;
                        rd_reg    <= 4'hF;
                        busy_reg  <= 1'b1;
                    end
                end
                READ: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    payload_reg  <= fifoOut;
                    idx_reg      <= 4'd0;
                    tx_data_reg  <= FRAME_HDR;
                    tx_start_reg <= 1'b1;
                    state_reg    <= SEND;
                end
                SEND: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (txDone) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg       <= IDLE;
                            busy_reg        <= 1'b0;
                            seq_reg         <= seq_reg + 8'd1;
                            frame_count_reg <= frame_count_reg + 16'd1;
                        end else begin
                            idx_reg      <= idx_next;
                            tx_data_reg  <= byte_next;
                            tx_start_reg <= 1'b1;
                            state_reg    <= SEND;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rd         = rd_reg;
    assign txData     = tx_data_reg;
    assign txStart    = tx_start_reg;
    assign busy       = busy_reg;
    assign frameCount = frame_count_reg;

endmodule

// File: tb/tb_image_frame_packer.sv
// Scoreboard bench for image_frame_packer: expected bytes are queued per frame and
// popped by a monitor on every txStart; a transmitter model answers with txDone.
module tb_image_frame_packer;

`ifdef FRAME_CHECKSUM_EN
    localparam int NBYTES = 11;
`else
    localparam int NBYTES = 10;
`endif

    logic        clk40M;
    logic        rst;
    logic        enable;
    logic [3:0]  empty;
    logic [3:0]  rd;
    logic [63:0] fifoOut;
    logic [7:0]  txData;
    logic        txStart;
    logic        txDone;
    logic        busy;
    logic [15:0] frameCount;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q [$];
    logic [63:0] words;
    int          frame_bytes;
    int          done_count;
    int          tx_delay;

    image_frame_packer #(.FRAME_HDR(8'hA5)) dut (
        .clk40M     (clk40M),
        .rst        (rst),
        .enable     (enable),
        .empty      (empty),
        .rd         (rd),
        .fifoOut    (fifoOut),
        .txData     (txData),
        .txStart    (txStart),
        .txDone     (txDone),
        .busy       (busy),
        .frameCount (frameCount)
    );

    initial begin
        clk40M = 1'b0;
        forever #5 clk40M = ~clk40M;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [63:0] w, input logic [7:0] s, input int k);
        logic [7:0] c;
        if (k == 0) return 8'hA5;
        if (k == 1) return s;
        if (k < 10) return w[8*(k-2) +: 8];
        c = s;
        for (int j = 0; j < 8; j++) c = c ^ w[8*j +: 8];
        return c;
    endfunction

    task automatic push_frame(input logic [63:0] w, input logic [7:0] s);
        words = w;
        frame_bytes = 0;
        for (int k = 0; k < NBYTES; k++) exp_q.push_back(model_byte(w, s, k));
    endtask

    task automatic start_frame();
        int n;
        empty  = 4'h0;
        enable = 1'b1;
        n = 0;
        while (rd !== 4'hF && n < 20) begin
            @(negedge clk40M);
            n++;
        end
        chk("rd_pulse", rd, 4'hF);
        chk("busy_high", busy, 1'b1);
        enable = 1'b0;
        empty  = 4'hF;
        @(negedge clk40M);
        chk("rd_one_cycle", rd, 4'h0);
    endtask

    task automatic wait_frame_end(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk40M);
            n++;
        end
        chk("frame_end", busy, 1'b0);
        chk("byte_count", frame_bytes, NBYTES);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // FIFO model: words appear only in the cycle after rd, garbage otherwise.
    initial begin
        bit rd_prev;
        fifoOut = 64'h0;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk40M);
            fifoOut = rd_prev ? words : 64'hBAD0_BAD0_BAD0_BAD0;
            rd_prev = (rd === 4'hF);
        end
    end

    // Monitor: every txStart consumes one expected byte.
    initial begin
        forever begin
            @(negedge clk40M);
            if (rst === 1'b0 && rd !== 4'h0) chk("rd_all_channels", rd, 4'hF);
            if (rst === 1'b0 && txStart === 1'b1) begin
                frame_bytes++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_txstart actual=%0h required=none", txData);
                end else begin
                    chk("tx_byte", txData, exp_q.pop_front());
                end
            end
        end
    end

    // Transmitter model: txDone tx_delay cycles after txStart; txData must hold meanwhile.
    initial begin
        bit         pending;
        bit         changed;
        int         remain;
        logic [7:0] held;
        txDone = 1'b0;
        done_count = 0;
        pending = 1'b0;
        changed = 1'b0;
        remain = 0;
        held = 8'h00;
        forever begin
            @(negedge clk40M);
            txDone = 1'b0;
            if (rst !== 1'b0) begin
                pending = 1'b0;
            end else if (pending) begin
                if (txData !== held || txStart !== 1'b0) changed = 1'b1;
                remain--;
                if (remain <= 0) begin
                    chk("txdata_hold", changed, 1'b0);
                    txDone = 1'b1;
                    done_count++;
                    pending = 1'b0;
                end
            end else if (txStart === 1'b1) begin
                pending = 1'b1;
                held = txData;
                changed = 1'b0;
                remain = tx_delay;
            end
        end
    end

    initial begin
        logic [7:0] s1 [0:10];
        bit         flag;
        int         base;
        int         n;

        s1 = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h00, 8'hDE, 8'hF0};
        rst = 1'b1;
        enable = 1'b0;
        empty = 4'hF;
        words = 64'h0;
        tx_delay = 1;
        frame_bytes = 0;

        repeat (3) @(negedge clk40M);
        chk("reset_rd", rd, 4'h0);
        chk("reset_txStart", txStart, 1'b0);
        chk("reset_txData", txData, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frameCount", frameCount, 16'h0);
        rst = 1'b0;
        @(negedge clk40M);

        // Frame content with hand-computed bytes.
        words = {16'hDE00, 16'h9ABC, 16'h5678, 16'h1234};
        frame_bytes = 0;
        for (int k = 0; k < NBYTES; k++) exp_q.push_back(s1[k]);
        start_frame();
        wait_frame_end(100);
        chk("frameCount_1", frameCount, 16'd1);

        // Partial empty holds off the read, then one rd a cycle after clearing.
        push_frame(64'h0F0E_0D0C_0B0A_0908, 8'h01);
        empty = 4'b0100;
        enable = 1'b1;
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk40M);
            if (rd !== 4'h0 || busy !== 1'b0) flag = 1'b1;
        end
        chk("partial_empty_hold", flag, 1'b0);
        empty = 4'h0;
        @(negedge clk40M);
        chk("rd_after_clear", rd, 4'hF);
        enable = 1'b0;
        empty = 4'hF;
        @(negedge clk40M);
        chk("rd_after_clear_one_cycle", rd, 4'h0);
        wait_frame_end(100);
        chk("frameCount_2", frameCount, 16'd2);

        // Slow transmitter.
        tx_delay = 100;
        push_frame(64'hFEDC_BA98_7654_3210, 8'h02);
        start_frame();
        wait_frame_end(NBYTES * 110 + 20);
        tx_delay = 1;
        chk("frameCount_3", frameCount, 16'd3);

        // Reset after the 5th txDone of a frame.
        base = done_count;
        push_frame(64'h1111_2222_3333_4444, 8'h03);
        start_frame();
        n = 0;
        while (done_count < base + 5 && n < 100) begin
            @(negedge clk40M);
            n++;
        end
        chk("five_done_seen", (done_count >= base + 5), 1'b1);
        @(posedge clk40M);
        #2 rst = 1'b1;
        #1;
        chk("midreset_rd", rd, 4'h0);
        chk("midreset_txStart", txStart, 1'b0);
        chk("midreset_txData", txData, 8'h00);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_frameCount", frameCount, 16'h0);
        repeat (3) @(negedge clk40M);
        chk("midreset_hold_busy", busy, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk40M);

        // 257 consecutive frames: seq restarts at 0 and wraps back to 0 on the last one.
        for (int f = 0; f < 257; f++) begin
            push_frame({16'(f * 3), 16'hC0DE, 16'(f), 16'h1357 ^ 16'(f)}, f[7:0]);
            start_frame();
            wait_frame_end(200);
            if (f == 0) chk("frameCount_after_reset", frameCount, 16'd1);
        end
        chk("frameCount_257", frameCount, 16'd257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
